// File: rtl/reg_bank16_if.sv
// ---------------------------------------------------------------------------
// reg_bank16_if
// Write-back and bulk-clear signals of the sixteen-entry register bank.
//   wr_valid  (master->slave) write request present
//   wr_ready  (slave->master) bank can accept a write this cycle
//   wr_addr   (master->slave) destination register index, 4 bits
//   wr_data   (master->slave) value to write, DATA_W bits
//   clr_req   (master->slave) request a bulk clear of all registers
//   clr_busy  (slave->master) bulk clear in progress
// ---------------------------------------------------------------------------
interface reg_bank16_if #(
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, clr_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, clr_busy
    );
endinterface

// File: rtl/reg_bank16.sv
// ---------------------------------------------------------------------------
// reg_bank16
// Sixteen-entry register storage feeding the register read-select mux.
// One write per cycle through a valid/ready handshake, plus a sequenced
// bulk clear that zeroes one register per cycle starting at CLR_START and
// walking upward modulo 16. Writes are refused while the clear runs.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-high reset
//   bus (reg_bank16_if.slave) wr_valid/wr_ready/wr_addr/wr_data,
//                            clr_req/clr_busy
//   data_out0..data_out15    registered value of each register
//
// Optional build macro:
//   REG_BANK16_R0_ZERO_EN    register 0 hardwired to zero; writes to
//                            address 0 complete the handshake but are dropped.
// ---------------------------------------------------------------------------
module reg_bank16 #(
    parameter int DATA_W    = 16,
    parameter int CLR_START = 0
) (
    input  logic              clk,
    input  logic              reset,
    reg_bank16_if.slave       bus,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic [DATA_W-1:0] data_out4,
    output logic [DATA_W-1:0] data_out5,
    output logic [DATA_W-1:0] data_out6,
    output logic [DATA_W-1:0] data_out7,
    output logic [DATA_W-1:0] data_out8,
    output logic [DATA_W-1:0] data_out9,
    output logic [DATA_W-1:0] data_out10,
    output logic [DATA_W-1:0] data_out11,
    output logic [DATA_W-1:0] data_out12,
    output logic [DATA_W-1:0] data_out13,
    output logic [DATA_W-1:0] data_out14,
    output logic [DATA_W-1:0] data_out15
);

    localparam logic [3:0] CLR_START_IDX = CLR_START[3:0];

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        cnt_inc;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (bus.wr_valid) begin
                    regs_d[bus.wr_addr] = bus.wr_data;
                end
                // A write accepted on the same edge still lands; the sweep
                // zeroes it again later, so the net result is all zeros.
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = CLR_START_IDX;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_inc;
                // The walk has covered all sixteen entries once the index
                // is about to wrap back onto its starting point.
                if (cnt_inc == CLR_START_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef REG_BANK16_R0_ZERO_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs_q[gi] <= '0;
            end else begin
                regs_q[gi] <= regs_d[gi];
            end
        end
    end

    // Handshake flags come from the state register alone.
    assign bus.wr_ready = (state_q == IDLE);
    assign bus.clr_busy = (state_q == CLEAR);

    assign data_out0  = regs_q[0];
    assign data_out1  = regs_q[1];
    assign data_out2  = regs_q[2];
    assign data_out3  = regs_q[3];
    assign data_out4  = regs_q[4];
    assign data_out5  = regs_q[5];
    assign data_out6  = regs_q[6];
    assign data_out7  = regs_q[7];
    assign data_out8  = regs_q[8];
    assign data_out9  = regs_q[9];
    assign data_out10 = regs_q[10];
    assign data_out11 = regs_q[11];
    assign data_out12 = regs_q[12];
    assign data_out13 = regs_q[13];
    assign data_out14 = regs_q[14];
    assign data_out15 = regs_q[15];

endmodule

// File: tb/tb_reg_bank16.sv
// ---------------------------------------------------------------------------
// tb_reg_bank16
// Directed scenarios followed by randomized traffic. A behavioural model
// (array of register values plus a count of remaining clear cycles) is
// updated on every clock and compared against all DUT outputs on each
// falling edge; a few literal checks pin the model's behaviour.
// ---------------------------------------------------------------------------
module tb_reg_bank16;

    localparam int DATA_W    = 16;
    localparam int CLR_START = 0;

    logic clk;
    logic reset;
    logic [DATA_W-1:0] dout [16];

    int vectors;
    int miscompares;

    reg_bank16_if #(.DATA_W(DATA_W)) bus ();

    reg_bank16 #(
        .DATA_W   (DATA_W),
        .CLR_START(CLR_START)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .data_out0 (dout[0]),
        .data_out1 (dout[1]),
        .data_out2 (dout[2]),
        .data_out3 (dout[3]),
        .data_out4 (dout[4]),
        .data_out5 (dout[5]),
        .data_out6 (dout[6]),
        .data_out7 (dout[7]),
        .data_out8 (dout[8]),
        .data_out9 (dout[9]),
        .data_out10(dout[10]),
        .data_out11(dout[11]),
        .data_out12(dout[12]),
        .data_out13(dout[13]),
        .data_out14(dout[14]),
        .data_out15(dout[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_regs [16];
    int                m_clear_left;   // clear cycles still to run, 0 = idle

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= '0;
            m_clear_left <= 0;
        end else if (m_clear_left > 0) begin
            m_regs[(CLR_START + 16 - m_clear_left) % 16] <= '0;
            m_clear_left <= m_clear_left - 1;
        end else begin
            if (bus.wr_valid) begin
`ifdef REG_BANK16_R0_ZERO_EN
                if (bus.wr_addr != 4'd0) m_regs[bus.wr_addr] <= bus.wr_data;
`else
                m_regs[bus.wr_addr] <= bus.wr_data;
`endif
            end
            if (bus.clr_req) m_clear_left <= 16;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("wr_ready", {31'd0, bus.wr_ready}, {31'd0, (m_clear_left == 0)});
        chk("clr_busy", {31'd0, bus.clr_busy}, {31'd0, (m_clear_left != 0)});
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("data_out%0d", i), {16'd0, dout[i]}, {16'd0, m_regs[i]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [3:0] a, input logic [DATA_W-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.clr_busy && n < 40) begin
            n++;
            tick();
        end
        if (bus.clr_busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    int  n;
    logic [DATA_W-1:0] lit0;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        #23;
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
        chk("rst_clr_busy", {31'd0, bus.clr_busy}, 32'd0);
        chk("rst_dout7", {16'd0, dout[7]}, 32'd0);

        // Two back-to-back writes
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'h1234;
        tick();
        chk("w1_dout5", {16'd0, dout[5]}, 32'h1234);
        bus.wr_addr = 4'd15; bus.wr_data = 16'hBEEF;
        tick();
        bus.wr_valid = 1'b0;
        chk("w2_dout15", {16'd0, dout[15]}, 32'hBEEF);
        chk("w2_dout4", {16'd0, dout[4]}, 32'h0);

        // Fill, then sweep from register 0
        for (int i = 0; i < 16; i++) write1(i[3:0], 16'h1000 + i[15:0]);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        n = 0;
        while (bus.clr_busy && n < 40) begin
            chk("clr_ready_low", {31'd0, bus.wr_ready}, 32'd0);
            n++;
            tick();
            if (n == 8) begin
                chk("clr8_dout7", {16'd0, dout[7]}, 32'h0);
                chk("clr8_dout8", {16'd0, dout[8]}, 32'h1008);
            end
        end
        chk("clr_busy_cycles", n, 32'd16);
        chk("clr_end_ready", {31'd0, bus.wr_ready}, 32'd1);
        chk("clr_end_dout15", {16'd0, dout[15]}, 32'h0);

        // Write held during a clear; clr_req re-pulsed mid-sweep is ignored
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hAAAA;
        for (int i = 0; i < 5; i++) begin
            bus.clr_req = (i >= 2);
            tick();
        end
        bus.clr_req = 1'b0;
        n = 0;
        while (!bus.wr_ready && n < 40) begin
            n++;
            tick();
        end
        chk("hold_wait", n, 32'd11);
        tick();
        bus.wr_valid = 1'b0;
        chk("hold_dout3", {16'd0, dout[3]}, 32'hAAAA);

        // Simultaneous clr_req and write
        bus.clr_req = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h5555;
        tick();
        bus.clr_req = 1'b0; bus.wr_valid = 1'b0;
        chk("same_dout9", {16'd0, dout[9]}, 32'h5555);
        wait_idle("same");
        chk("same_end_dout9", {16'd0, dout[9]}, 32'h0);

        // Asynchronous reset in the middle of a clear
        for (int i = 0; i < 16; i++) write1(i[3:0], 16'hFFFF);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (7) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.clr_busy}, 32'd0);
        chk("arst_ready", {31'd0, bus.wr_ready}, 32'd1);
        chk("arst_dout12", {16'd0, dout[12]}, 32'h0);
        #5;
        reset = 1'b0;
        tick();

        // Register 0 write
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'h7777;
        chk("r0_ready", {31'd0, bus.wr_ready}, 32'd1);
        tick();
        bus.wr_valid = 1'b0;
`ifdef REG_BANK16_R0_ZERO_EN
        lit0 = 16'h0000;
`else
        lit0 = 16'h7777;
`endif
        chk("r0_dout0", {16'd0, dout[0]}, {16'd0, lit0});

        // Randomized traffic; the address/data stay put while a write waits
        for (int c = 0; c < 2000; c++) begin
            if (!(bus.wr_valid && !bus.wr_ready)) begin
                bus.wr_valid = ($urandom_range(0, 1) == 1);
                bus.wr_addr  = 4'($urandom_range(0, 15));
                bus.wr_data  = 16'($urandom);
            end
            bus.clr_req = ($urandom_range(0, 40) == 0);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        wait_idle("rand");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
